// File: rtl/quantum_program_sequencer.sv
// Host-side gate program sequencer: steps through a loaded opcode program, issues each
// opcode to the quantum controller with a busy handshake and collects measurement bits.
module quantum_program_sequencer #(
  parameter int PROG_DEPTH  = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 8,
  parameter int MAX_MEAS    = 8,
  parameter int CNT_W       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                prog_we,
  input  logic [ADDR_W-1:0]   prog_addr,
  input  logic [2:0]          prog_data,
  input  logic                start,
  input  logic                abort,
  output logic [2:0]          cmd_gate,
  output logic                cmd_execute,
  input  logic                ctrl_busy,
  input  logic                ctrl_measure_result,
  output logic                seq_busy,
  output logic                seq_done,
  output logic                seq_error,
  output logic [ADDR_W-1:0]   pc,
  output logic [MAX_MEAS-1:0] meas_bits,
  output logic [CNT_W-1:0]    meas_count
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FETCH     = 3'd1;
  localparam logic [2:0] ISSUE     = 3'd2;
  localparam logic [2:0] WAIT_ACK  = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
  localparam logic [2:0] CAPTURE   = 3'd5;
  localparam logic [2:0] NEXT      = 3'd6;
  localparam logic [2:0] DONE      = 3'd7;

  localparam logic [2:0] OP_HALT = 3'b000;
  localparam logic [2:0] OP_MEAS = 3'b101;

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  logic [2:0]      state;
  logic [TO_W-1:0] ack_cnt;
  logic [2:0]      fetch_op;
  logic [2:0]      prog_mem [PROG_DEPTH];

  // Measurement count sticks at MAX_MEAS once the result vector is full.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c < CNT_W'(MAX_MEAS)) ? c + CNT_W'(1) : c;
  endfunction

  // Program store has no reset so a loaded program survives a sequencer reset.
  always_ff @(posedge clk) begin
    if (prog_we && state == IDLE) prog_mem[prog_addr] <= prog_data;
  end

  assign fetch_op = prog_mem[pc];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ack_cnt    <= '0;
      cmd_gate   <= '0;
      seq_error  <= 1'b0;
      pc         <= '0;
      meas_bits  <= '0;
      meas_count <= '0;
    end else if (abort && state != IDLE) begin
      state    <= IDLE;
      cmd_gate <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort && !ctrl_busy) begin
            pc         <= '0;
            meas_bits  <= '0;
            meas_count <= '0;
            seq_error  <= 1'b0;
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (fetch_op == OP_HALT) begin
            state <= DONE;
          end else begin
            cmd_gate <= fetch_op;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          ack_cnt <= '0;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ctrl_busy) begin
            state <= WAIT_DONE;
          end else if (ack_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
            seq_error <= 1'b1;
            cmd_gate  <= '0;
            state     <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + TO_W'(1);
          end
        end
        WAIT_DONE: begin
          // cmd_gate still holds the issued opcode here, so it selects the capture path.
          if (!ctrl_busy) begin
            cmd_gate <= '0;
            state    <= (cmd_gate == OP_MEAS) ? CAPTURE : NEXT;
          end
        end
        CAPTURE: begin
          for (int i = 0; i < MAX_MEAS; i++) begin
            if (meas_count == CNT_W'(i)) meas_bits[i] <= ctrl_measure_result;
          end
          meas_count <= sat_inc(meas_count);
          state      <= NEXT;
        end
        NEXT: begin
          cmd_gate <= '0;
          if (pc == ADDR_W'(PROG_DEPTH - 1)) begin
            state <= DONE;
          end else begin
            pc    <= pc + ADDR_W'(1);
            state <= FETCH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_execute = (state == ISSUE);
  assign seq_done    = (state == DONE);
  assign seq_busy    = (state != IDLE);

endmodule

// File: tb/tb_quantum_program_sequencer.sv
// Bench for quantum_program_sequencer: table of programs run against a controller
// responder, plus directed timeout, abort, write-protect and async-reset sequences.
module tb_quantum_program_sequencer;
  localparam int PROG_DEPTH = 16, ADDR_W = 4, ACK_TIMEOUT = 8, MAX_MEAS = 8, CNT_W = 4;

  logic clk, reset, prog_we, start, abort;
  logic [ADDR_W-1:0] prog_addr;
  logic [2:0] prog_data, cmd_gate;
  logic cmd_execute, ctrl_busy, ctrl_measure_result, seq_busy, seq_done, seq_error;
  logic [ADDR_W-1:0] pc;
  logic [MAX_MEAS-1:0] meas_bits;
  logic [CNT_W-1:0] meas_count;

  quantum_program_sequencer #(
    .PROG_DEPTH(PROG_DEPTH), .ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT),
    .MAX_MEAS(MAX_MEAS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .abort(abort), .cmd_gate(cmd_gate),
    .cmd_execute(cmd_execute), .ctrl_busy(ctrl_busy),
    .ctrl_measure_result(ctrl_measure_result), .seq_busy(seq_busy),
    .seq_done(seq_done), .seq_error(seq_error), .pc(pc), .meas_bits(meas_bits),
    .meas_count(meas_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  logic resp_en = 1'b0;
  int resp_delay = 2;
  int resp_len = 5;
  logic [31:0] meas_pat = '0;
  int resp_idx = 0;

  int pulse_cnt = 0;
  int done_cnt = 0;
  logic [2:0] gate_log [32];

  typedef struct {
    string               name;
    logic [15:0][2:0]    prog;
    logic [31:0]         pat;
    int                  exp_pulses;
    logic [MAX_MEAS-1:0] exp_bits;
    logic [CNT_W-1:0]    exp_count;
    logic [ADDR_W-1:0]   exp_pc;
  } vec_t;
  vec_t vecs[5];

  // Controller model: busy rises resp_delay edges after a pulse, holds resp_len edges.
  initial begin
    ctrl_busy = 1'b0;
    ctrl_measure_result = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_execute === 1'b1 && resp_en && !reset) begin
        repeat (resp_delay) @(posedge clk);
        #1;
        ctrl_measure_result = meas_pat[resp_idx % 32];
        resp_idx++;
        ctrl_busy = 1'b1;
        repeat (resp_len) @(posedge clk);
        #1 ctrl_busy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmd_execute === 1'b1) begin
        if (pulse_cnt < 32) gate_log[pulse_cnt] = cmd_gate;
        pulse_cnt++;
      end
      if (seq_done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_prog(input logic [15:0][2:0] p);
    for (int i = 0; i < PROG_DEPTH; i++) begin
      @(negedge clk);
      prog_we = 1'b1;
      prog_addr = ADDR_W'(i);
      prog_data = p[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic clear_mon();
    pulse_cnt = 0;
    done_cnt = 0;
    resp_idx = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [15:0][2:0] p;
    int k;
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0; abort = 1'b0;

    vecs[0].name = "two_gates"; vecs[0].prog = '0;
    vecs[0].prog[0] = 3'b001; vecs[0].prog[1] = 3'b010;
    vecs[0].pat = 32'h0; vecs[0].exp_pulses = 2;
    vecs[0].exp_bits = 8'h00; vecs[0].exp_count = 4'd0; vecs[0].exp_pc = 4'd2;

    vecs[1].name = "three_meas"; vecs[1].prog = '0;
    for (int i = 0; i < 3; i++) vecs[1].prog[i] = 3'b101;
    vecs[1].pat = 32'b101; vecs[1].exp_pulses = 3;
    vecs[1].exp_bits = 8'b0000_0101; vecs[1].exp_count = 4'd3; vecs[1].exp_pc = 4'd3;

    vecs[2].name = "sixteen_meas";
    for (int i = 0; i < 16; i++) vecs[2].prog[i] = 3'b101;
    vecs[2].pat = 32'h0000_A5C3; vecs[2].exp_pulses = 16;
    vecs[2].exp_bits = 8'hC3; vecs[2].exp_count = 4'd8; vecs[2].exp_pc = 4'd15;

    vecs[3].name = "mixed"; vecs[3].prog = '0;
    vecs[3].prog[0] = 3'b011; vecs[3].prog[1] = 3'b101;
    vecs[3].prog[2] = 3'b111; vecs[3].prog[3] = 3'b101;
    vecs[3].pat = 32'b1010; vecs[3].exp_pulses = 4;
    vecs[3].exp_bits = 8'b0000_0011; vecs[3].exp_count = 4'd2; vecs[3].exp_pc = 4'd4;

    vecs[4].name = "halt_first"; vecs[4].prog = '0;
    vecs[4].pat = 32'hFFFF_FFFF; vecs[4].exp_pulses = 0;
    vecs[4].exp_bits = 8'h00; vecs[4].exp_count = 4'd0; vecs[4].exp_pc = 4'd0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({cmd_gate, cmd_execute, seq_busy, seq_done, seq_error,
                              pc, meas_bits, meas_count}), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      load_prog(vecs[v].prog);
      clear_mon();
      meas_pat = vecs[v].pat; resp_en = 1'b1; resp_delay = 2; resp_len = 5;
      pulse_start();
      wait_done(vecs[v].name);
      chk($sformatf("%s_pulses", vecs[v].name), 64'(pulse_cnt), 64'(vecs[v].exp_pulses));
      for (int g = 0; g < vecs[v].exp_pulses && g < 16; g++)
        chk($sformatf("%s_gate%0d", vecs[v].name, g), 64'(gate_log[g]), 64'(vecs[v].prog[g]));
      chk($sformatf("%s_done_once", vecs[v].name), 64'(done_cnt), 64'd1);
      chk($sformatf("%s_meas_bits", vecs[v].name), 64'(meas_bits), 64'(vecs[v].exp_bits));
      chk($sformatf("%s_meas_count", vecs[v].name), 64'(meas_count), 64'(vecs[v].exp_count));
      chk($sformatf("%s_pc", vecs[v].name), 64'(pc), 64'(vecs[v].exp_pc));
      chk($sformatf("%s_idle", vecs[v].name), 64'({seq_busy, seq_error, cmd_gate}), 64'd0);
    end

    // Handshake timeout: controller never answers.
    p = '0; p[0] = 3'b001;
    load_prog(p);
    clear_mon(); resp_en = 1'b0;
    pulse_start();
    @(negedge clk);
    chk("latency_execute", 64'(cmd_execute), 64'd1);
    chk("issue_gate", 64'(cmd_gate), 64'd1);
    k = 0;
    while (seq_error !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    // Pulse cycle, then 8 waiting cycles; flag appears in the following cycle.
    chk("timeout_cycles", 64'(k), 64'd9);
    chk("timeout_idle", 64'({seq_busy, cmd_gate}), 64'd0);
    repeat (3) @(negedge clk);
    chk("timeout_no_done", 64'(done_cnt), 64'd0);
    chk("timeout_sticky", 64'(seq_error), 64'd1);
    clear_mon(); resp_en = 1'b1; resp_len = 5;
    pulse_start();
    chk("error_cleared", 64'(seq_error), 64'd0);
    wait_done("rerun");
    chk("rerun_clean", 64'({seq_error, 4'(pulse_cnt)}), 64'd1);

    // Abort during WAIT_DONE, blocked start while the controller is busy.
    p = '0; p[0] = 3'b001; p[1] = 3'b010;
    load_prog(p);
    clear_mon(); resp_en = 1'b1; resp_delay = 2; resp_len = 12;
    pulse_start();
    k = 0;
    while (ctrl_busy !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", 64'({seq_busy, cmd_gate}), 64'({1'b1, 3'b001}));
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_idle", 64'({seq_busy, cmd_execute, cmd_gate}), 64'd0);
    pulse_start();
    @(negedge clk);
    chk("start_blocked", 64'(seq_busy), 64'd0);
    k = 0;
    while (ctrl_busy === 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk("abort_no_pulse", 64'(pulse_cnt), 64'd1);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    chk("start_abort_idle", 64'(seq_busy), 64'd0);
    clear_mon(); resp_len = 5;
    pulse_start();
    wait_done("after_abort");
    chk("after_abort_pulses", 64'(pulse_cnt), 64'd2);
    chk("after_abort_gate0", 64'(gate_log[0]), 64'd1);
    chk("after_abort_pc", 64'(pc), 64'd2);

    // Writes during execution must be ignored.
    p = '0; p[0] = 3'b011; p[1] = 3'b101;
    load_prog(p);
    clear_mon(); meas_pat = 32'h2;
    pulse_start();
    repeat (2) @(negedge clk);
    chk("we_running", 64'(seq_busy), 64'd1);
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 3'b110;
    @(negedge clk) begin prog_addr = 4'd1; prog_data = 3'b000; end
    @(negedge clk) prog_we = 1'b0;
    wait_done("we_first");
    clear_mon();
    pulse_start();
    wait_done("we_second");
    chk("we_pulses", 64'(pulse_cnt), 64'd2);
    chk("we_gates", 64'({gate_log[0], gate_log[1]}), 64'({3'b011, 3'b101}));
    chk("we_meas", 64'({meas_bits, meas_count}), 64'({8'h01, 4'd1}));

    // Asynchronous reset while waiting for the handshake.
    p = '0; p[0] = 3'b001;
    load_prog(p);
    clear_mon(); resp_en = 1'b0;
    pulse_start();
    repeat (4) @(negedge clk);
    chk("pre_reset_wait", 64'({seq_busy, cmd_gate}), 64'({1'b1, 3'b001}));
    #2 reset = 1'b1;
    #1 chk("async_reset", 64'({cmd_gate, cmd_execute, seq_busy, seq_done, seq_error,
                               pc, meas_bits, meas_count}), 64'd0);
    @(negedge clk) reset = 1'b0;
    clear_mon(); resp_en = 1'b1;
    pulse_start();
    wait_done("post_reset");
    chk("post_reset_prog", 64'({4'(pulse_cnt), gate_log[0]}), 64'({4'd1, 3'b001}));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
